regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter AW, default 5: address width; register count NREGS = 2**AW.
REQ-003 SHALL have parameter ZERO_REG, default 1: 1 = register 0 hardwired to zero, 0 = register 0 is ordinary storage.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clock, input, 1: rising-edge clock for all state.
REQ-006 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port we, input, 1: write enable.
REQ-008 SHALL have port waddr, input, AW: write register index.
REQ-009 SHALL have port wdata, input, XLEN: write data.
REQ-010 SHALL have ports re1 and re2, input, 1 each: read-port enables.
REQ-011 SHALL have ports raddr1 and raddr2, input, AW each: read indices.
REQ-012 SHALL have ports rdata1 and rdata2, output, XLEN each: registered read data.
REQ-013 SHALL have ports busy1 and busy2, output, 1 each: registered scoreboard bit of the register read.
REQ-014 SHALL have port issue, input, 1: marks register issue_addr as pending write.
REQ-015 SHALL have port issue_addr, input, AW: register index to mark pending.
REQ-016 SHALL have port pend_cnt, output, AW+1: number of registers currently marked pending.

Function
REQ-017 SHALL update storage on the rising edge of clock when we=1: reg[waddr] <= wdata.
REQ-018 SHALL ignore writes to index 0 when ZERO_REG=1; rdata for index 0 SHALL then always be 0.
REQ-019 SHALL give 1-cycle read latency: re1=1 at edge N loads rdata1 at edge N; value visible in cycle N+1. Port 2 is identical and independent.
REQ-020 SHALL hold rdata1/busy1 (resp. port 2) unchanged on any edge where re1 (re2) = 0.
REQ-021 SHALL bypass: when we=1, waddr==raddr1, re1=1 at the same edge, rdata1 SHALL load wdata, not the old contents. ZERO_REG rule overrides bypass.
REQ-022 SHALL allow both read ports to hit the same index, including under bypass, with identical results.
REQ-023 SHALL keep a busy bit per register: issue=1 sets busy[issue_addr]; we=1 clears busy[waddr].
REQ-024 SHALL, on the same edge as issue and we to the same index, leave busy set (issue wins; newer write pending).
REQ-025 SHALL ignore issue to index 0 when ZERO_REG=1; busy[0] stays 0.
REQ-026 SHALL clear a busy bit on any write, whether or not it was set; clearing a clear bit has no effect on pend_cnt.
REQ-027 SHALL load busy1 with the next-state busy value of raddr1 (after that edge's set/clear), same rule for busy2.
REQ-028 SHALL maintain pend_cnt as a registered count equal to the population of busy bits: +1 on a 0->1 transition, -1 on a 1->0 transition, unchanged when both occur on different indices or neither occurs; range 0..NREGS, no wrap.
REQ-029 SHALL treat issue to an already-busy register as no count change.

Reset
REQ-030 SHALL, while reset_n=0, asynchronously clear all registers, all busy bits, rdata1, rdata2, busy1, busy2 to 0 and pend_cnt to 0.
REQ-031 SHALL ignore we, issue, re1, re2 while reset_n=0; reset mid-operation discards pending writes and scoreboard state.
REQ-032 SHALL resume normal operation on the first rising edge with reset_n=1.

Verification
REQ-033 Write 0xDEADBEEF to reg 5, next cycle re1=1 raddr1=5 -> rdata1=0xDEADBEEF one cycle later.
REQ-034 we=1 waddr=7 wdata=0x12345678 with re1=re2=1 raddr1=raddr2=7 same edge -> rdata1=rdata2=0x12345678 next cycle.
REQ-035 ZERO_REG=1: write 0xFFFFFFFF to reg 0, read reg 0 -> rdata=0; issue_addr=0 -> pend_cnt stays 0.
REQ-036 issue regs 3 and 9, then we to 3 and issue 3 same edge -> busy[3]=1, pend_cnt=2; read raddr1=9 -> busy1=1.
REQ-037 issue regs 1,2,4 (pend_cnt=3), then we to 2 and issue 6 same edge -> pend_cnt stays 3; re1=0 for 3 cycles -> rdata1 unchanged.
REQ-038 Fill regs 1..31 and issue all, assert reset_n=0 mid-cycle -> all outputs 0 immediately; after release reads of reg 10 return 0, pend_cnt=0.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with two registered read ports, write bypass and busy-bit scoreboard
// Register 0 can be hardwired to zero; pend_cnt tracks the number of pending (busy) registers.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re1,
    input  logic            re2,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            busy1,
    output logic            busy2,
    input  logic            issue,
    input  logic [AW-1:0]   issue_addr,
    output logic [AW:0]     pend_cnt
);
    localparam int NREGS = 2 ** AW;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nx;
    logic [XLEN-1:0] rd1_nx;
    logic [XLEN-1:0] rd2_nx;
    logic wr_ok;
    logic iss_ok;
    logic cnt_inc;
    logic cnt_dec;

    always_comb begin
        wr_ok   = we && !(ZR && waddr == '0);
        iss_ok  = issue && !(ZR && issue_addr == '0);
        // clear before set so a same-index issue keeps the register pending
        busy_nx = busy;
        if (we)
            busy_nx[waddr] = 1'b0;
        if (iss_ok)
            busy_nx[issue_addr] = 1'b1;
        cnt_inc = iss_ok && !busy[issue_addr];
        cnt_dec = we && busy[waddr] && !(iss_ok && issue_addr == waddr);

        if (ZR && raddr1 == '0)
            rd1_nx = '0;
        else if (wr_ok && waddr == raddr1)
            rd1_nx = wdata;
        else
            rd1_nx = regs[raddr1];

        if (ZR && raddr2 == '0)
            rd2_nx = '0;
        else if (wr_ok && waddr == raddr2)
            rd2_nx = wdata;
        else
            rd2_nx = regs[raddr2];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy     <= '0;
            rdata1   <= '0;
            rdata2   <= '0;
            busy1    <= 1'b0;
            busy2    <= 1'b0;
            pend_cnt <= '0;
        end else begin
            if (wr_ok)
                regs[waddr] <= wdata;
            busy <= busy_nx;
            if (re1) begin
                rdata1 <= rd1_nx;
                busy1  <= busy_nx[raddr1];
            end
            if (re2) begin
                rdata2 <= rd2_nx;
                busy2  <= busy_nx[raddr2];
            end
            if (cnt_inc && !cnt_dec)
                pend_cnt <= pend_cnt + 1'b1;
            else if (cnt_dec && !cnt_inc)
                pend_cnt <= pend_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb
// Directed vector table, reset corner sequence and randomized traffic against a behavioural model.
module tb_regfile_sb;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        busy1, busy2;
    logic        issue;
    logic [4:0]  issue_addr;
    logic [5:0]  pend_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.XLEN(32), .AW(5), .ZERO_REG(1)) dut (
        .clock(clock), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .busy1(busy1), .busy2(busy2),
        .issue(issue), .issue_addr(issue_addr), .pend_cnt(pend_cnt)
    );

    always #5 clock = ~clock;

    logic [31:0] m_mem [32];
    bit          m_busy [32];
    logic [31:0] m_rd1, m_rd2;
    bit          m_b1, m_b2;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic        iss;
        logic [4:0]  ia;
        logic [31:0] e_rd1;
        logic        e_b1;
        logic [31:0] e_rd2;
        logic        e_b2;
        logic [5:0]  e_pend;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd,
                                logic r1, logic [4:0] a1, logic r2, logic [4:0] a2,
                                logic is, logic [4:0] ia,
                                logic [31:0] e1, logic b1, logic [31:0] e2, logic b2,
                                logic [5:0] ep);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.re1 = r1; v.ra1 = a1; v.re2 = r2; v.ra2 = a2;
        v.iss = is; v.ia = ia; v.e_rd1 = e1; v.e_b1 = b1; v.e_rd2 = e2; v.e_b2 = b2;
        v.e_pend = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pend();
        int n = 0;
        for (int i = 0; i < 32; i++)
            n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_rd1 = '0; m_rd2 = '0; m_b1 = 1'b0; m_b2 = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rdata1"}, rdata1, m_rd1);
        chk({tag, ".rdata2"}, rdata2, m_rd2);
        chk({tag, ".busy1"}, {31'd0, busy1}, {31'd0, m_b1});
        chk({tag, ".busy2"}, {31'd0, busy2}, {31'd0, m_b2});
        chk({tag, ".pend_cnt"}, {26'd0, pend_cnt}, model_pend());
    endtask

    // drive one cycle at the falling edge, advance the model at the rising edge, compare 1 ns later
    task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                         input logic is, input logic [4:0] ia, input string tag);
        @(negedge clock);
        we = w; waddr = wa; wdata = wd; re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
        issue = is; issue_addr = ia;
        @(posedge clock);
        if (w && wa != 5'd0)
            m_mem[wa] = wd;
        if (w)
            m_busy[wa] = 1'b0;
        if (is && ia != 5'd0)
            m_busy[ia] = 1'b1;
        if (r1) begin
            m_rd1 = m_mem[a1];
            m_b1  = m_busy[a1];
        end
        if (r2) begin
            m_rd2 = m_mem[a2];
            m_b2  = m_busy[a2];
        end
        #1;
        check_model(tag);
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0)
            return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        reset_n = 1'b0;
        we = 0; waddr = 0; wdata = 0; re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
        issue = 0; issue_addr = 0;
        model_reset();
        #3;
        check_model("reset");
        @(negedge clock);
        reset_n = 1'b1;

        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 32'hDEADBEEF, 0, 32'h0, 0, 0);
        vecs[2]  = mk(1, 7, 32'h12345678, 1, 7, 1, 7, 0, 0, 32'h12345678, 0, 32'h12345678, 0, 0);
        vecs[3]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, 0, 1, 5, 0, 0, 32'h0, 0, 32'hDEADBEEF, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h0, 0, 32'hDEADBEEF, 0, 1);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h0, 0, 32'hDEADBEEF, 0, 2);
        vecs[7]  = mk(1, 3, 32'hAA, 1, 9, 1, 3, 1, 3, 32'h0, 1, 32'hAA, 1, 2);
        vecs[8]  = mk(1, 3, 32'hAA, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'hAA, 1, 1);
        vecs[9]  = mk(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'hAA, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 1, 32'hAA, 1, 1);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h0, 1, 32'hAA, 1, 2);
        vecs[12] = mk(0, 0, 0, 1, 4, 0, 0, 1, 4, 32'h0, 1, 32'hAA, 1, 3);
        vecs[13] = mk(1, 2, 32'h22, 0, 0, 0, 0, 1, 6, 32'h0, 1, 32'hAA, 1, 3);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'hAA, 1, 3);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'hAA, 1, 3);
        vecs[16] = mk(0, 0, 0, 1, 2, 1, 9, 0, 0, 32'h22, 0, 32'h99, 0, 3);

        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re1, vecs[i].ra1,
                  vecs[i].re2, vecs[i].ra2, vecs[i].iss, vecs[i].ia, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_rdata1", i), rdata1, vecs[i].e_rd1);
            chk($sformatf("vec%0d.tbl_rdata2", i), rdata2, vecs[i].e_rd2);
            chk($sformatf("vec%0d.tbl_busy1", i), {31'd0, busy1}, {31'd0, vecs[i].e_b1});
            chk($sformatf("vec%0d.tbl_busy2", i), {31'd0, busy2}, {31'd0, vecs[i].e_b2});
            chk($sformatf("vec%0d.tbl_pend", i), {26'd0, pend_cnt}, {26'd0, vecs[i].e_pend});
        end

        // fill and mark every register pending, then reset in the middle of a cycle
        for (int i = 1; i < 32; i++)
            cycle(1, 5'(i), $urandom, 1, 5'(i), 0, 0, 1, 5'(i), "fill");
        cycle(0, 0, 0, 1, 10, 1, 31, 0, 0, "fill_rd");
        chk("fill.pend_full", {26'd0, pend_cnt}, 32'd31);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        we = 1; waddr = 10; wdata = 32'hCAFEF00D; issue = 1; issue_addr = 10;
        re1 = 1; raddr1 = 10; re2 = 1; raddr2 = 10;
        @(posedge clock);
        #1;
        check_model("rst_hold");
        @(negedge clock);
        reset_n = 1'b1;
        we = 0; issue = 0; re1 = 0; re2 = 0;
        cycle(0, 0, 0, 1, 10, 1, 10, 0, 0, "post_rst");
        chk("post_rst.rd10", rdata1, 32'h0);
        chk("post_rst.pend", {26'd0, pend_cnt}, 32'd0);

        for (int n = 0; n < 600; n++)
            cycle(1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                  1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(),
                  1'($urandom_range(0, 2) != 0), rnd_addr(), "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
